// File: rtl/pipe_stage_pkg.sv
// Shared types and sizing for the MEM->WB skid-buffered pipeline stage.
package pipe_stage_pkg;

  // Occupancy of the stage: no entry, main slot only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Payload packing is {fu, mem_result, pcplus, ctrl}, MSB first.
  function automatic int payload_w(input int data_w, input int ctrl_w);
    return 3 * data_w + ctrl_w;
  endfunction

endpackage

// File: rtl/stage_slot_reg.sv
// One payload-wide holding register with load enable; used for the main
// and skid slots of pipe_stage_skid.
module stage_slot_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Capture the payload on enable; cleared by async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// MEM->WB pipeline stage with valid/ready handshake, sync flush and a
// 2-entry (main + skid) buffer so in_ready_o is a flop output.
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating
// stall counter (stall_cnt_o, width CNT_W).
module pipe_stage_skid
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] fu_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic [DATA_W-1:0] pcplus_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] fu_o,
  output logic [DATA_W-1:0] mem_result_o,
  output logic [DATA_W-1:0] pcplus_o,
  output logic [CTRL_W-1:0] ctrl_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  localparam int PW = payload_w(DATA_W, CTRL_W);

  state_e          state_q, state_d;
  logic            in_ready_q;
  logic            in_fire, out_fire, out_valid;
  logic            main_en, skid_en;
  logic [PW-1:0]   in_pl, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] ctrl_raw;

  assign in_pl     = {fu_i, mem_result_i, pcplus_i, ctrl_i};
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid_i & in_ready_q;
  assign out_fire  = out_valid & out_ready_i;

  // Next occupancy and slot loads; flush overrides everything and drops
  // any same-cycle input. Skid only fills when main is blocked downstream,
  // so the skid entry is always older than anything arriving later.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_pl;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          main_en = 1'b1;
          main_d  = skid_q;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and registered ready: ready drops only when both slots will be held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  stage_slot_reg #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  stage_slot_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_en),
    .d_i   (in_pl),
    .q_o   (skid_q)
  );

  assign {fu_o, mem_result_o, pcplus_o, ctrl_raw} = main_q;
  // Bubbles must never carry live writeback control.
  assign ctrl_o      = out_valid ? ctrl_raw : '0;
  assign out_valid_o = out_valid;
  assign in_ready_o  = in_ready_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count cycles a valid output is held back; saturate, reset-only clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (out_valid && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a
// randomized run against a queue-based occupancy model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int PW = 3 * DW + CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] fu_i = '0, mem_result_i = '0, pcplus_i = '0;
  logic [CW-1:0] ctrl_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] fu_o, mem_result_o, pcplus_o;
  logic [CW-1:0] ctrl_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_o;
  logic [1:0]  stall_cnt2;
  logic        ir2, ov2;
  logic [DW-1:0] f2, m2, p2;
  logic [CW-1:0] c2;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(ir2), .fu_i(fu_i), .mem_result_i(mem_result_i),
    .pcplus_i(pcplus_i), .ctrl_i(ctrl_i), .out_valid_o(ov2),
    .out_ready_i(out_ready_i), .fu_o(f2), .mem_result_o(m2),
    .pcplus_o(p2), .ctrl_o(c2), .stall_cnt_o(stall_cnt2)
  );
`endif

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .fu_i(fu_i), .mem_result_i(mem_result_i),
    .pcplus_i(pcplus_i), .ctrl_i(ctrl_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .fu_o(fu_o), .mem_result_o(mem_result_o),
    .pcplus_o(pcplus_o), .ctrl_o(ctrl_o)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] f, input logic [CW-1:0] c);
    in_valid_i   = v;
    fu_i         = f;
    mem_result_i = f ^ 32'h5A5A_0000;
    pcplus_i     = f + 32'd4;
    ctrl_i       = c;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    out_ready_i = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 32'hDEAD, 8'hFF);
    out_ready_i = 1'b1;
    tick(); tick(); tick();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%h exp=00", ctrl_o); end
    total++; if (fu_o !== 32'h0) begin bad++; $display("FAIL reset_fu got=%h exp=0", fu_o); end
    drive(1'b0, '0, '0);
    reset = 1'b1;
    tick();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_streaming();
    apply_reset();
    out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, k, 8'(k + 8'h10));
      tick();
      total++;
      if (out_valid_o !== 1'b1 || fu_o !== 32'(k) || ctrl_o !== 8'(k + 8'h10) || in_ready_o !== 1'b1 ||
          pcplus_o !== 32'(k + 4)) begin
        bad++;
        $display("FAIL stream_%0d got v=%b fu=%0d ctrl=%h rdy=%b exp v=1 fu=%0d ctrl=%h rdy=1",
                 k, out_valid_o, fu_o, ctrl_o, in_ready_o, k, 8'(k + 8'h10));
      end
    end
    drive(1'b0, '0, '0);
    tick();
    total++; if (out_valid_o !== 1'b0 || ctrl_o !== 8'h00) begin bad++; $display("FAIL stream_drain got v=%b ctrl=%h exp v=0 ctrl=00", out_valid_o, ctrl_o); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA, 8'hA1); tick();
    total++; if (out_valid_o !== 1'b1 || fu_o !== 32'hA || in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_A got v=%b fu=%h rdy=%b exp v=1 fu=a rdy=1", out_valid_o, fu_o, in_ready_o); end
    drive(1'b1, 32'hB, 8'hB2); tick();
    total++; if (fu_o !== 32'hA || in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full got fu=%h rdy=%b exp fu=a rdy=0", fu_o, in_ready_o); end
    drive(1'b1, 32'hC, 8'hC3); tick(); tick();
    total++; if (fu_o !== 32'hA || ctrl_o !== 8'hA1 || mem_result_o !== (32'hA ^ 32'h5A5A_0000) || in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_hold got fu=%h ctrl=%h rdy=%b exp fu=a ctrl=a1 rdy=0", fu_o, ctrl_o, in_ready_o); end
    out_ready_i = 1'b1;
    tick();
    total++; if (out_valid_o !== 1'b1 || fu_o !== 32'hB || ctrl_o !== 8'hB2 || in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_B got v=%b fu=%h ctrl=%h rdy=%b exp v=1 fu=b ctrl=b2 rdy=1", out_valid_o, fu_o, ctrl_o, in_ready_o); end
    tick();
    total++; if (out_valid_o !== 1'b1 || fu_o !== 32'hC || ctrl_o !== 8'hC3) begin bad++; $display("FAIL bp_C got v=%b fu=%h ctrl=%h exp v=1 fu=c ctrl=c3", out_valid_o, fu_o, ctrl_o); end
    drive(1'b0, '0, '0); tick();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got v=%b exp 0", out_valid_o); end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h11, 8'h21); tick();
    drive(1'b1, 32'h12, 8'h22); tick();
    drive(1'b1, 32'hFF, 8'hEE);
    flush_i = 1'b1; tick();
    flush_i = 1'b0;
    total++; if (out_valid_o !== 1'b0 || ctrl_o !== 8'h00 || in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_full got v=%b ctrl=%h rdy=%b exp v=0 ctrl=00 rdy=1", out_valid_o, ctrl_o, in_ready_o); end
    // Flush in BUSY with an input that would otherwise be accepted.
    drive(1'b1, 32'h31, 8'h41); tick();
    drive(1'b1, 32'h32, 8'h42);
    flush_i = 1'b1; tick();
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    out_ready_i = 1'b1;
    total++; if (out_valid_o !== 1'b0 || ctrl_o !== 8'h00 || in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_busy got v=%b ctrl=%h rdy=%b exp v=0 ctrl=00 rdy=1", out_valid_o, ctrl_o, in_ready_o); end
    tick(); tick();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_dropped got v=%b fu=%h exp v=0", out_valid_o, fu_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h51, 8'h61); tick();
    drive(1'b1, 32'h52, 8'h62); tick();
    drive(1'b0, '0, '0);
    #3 reset = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0 || ctrl_o !== 8'h00 || in_ready_o !== 1'b1 || fu_o !== 32'h0) begin bad++; $display("FAIL async_reset got v=%b ctrl=%h rdy=%b fu=%h exp v=0 ctrl=00 rdy=1 fu=0", out_valid_o, ctrl_o, in_ready_o, fu_o); end
    tick();
    reset = 1'b1;
    out_ready_i = 1'b1;
    tick(); tick();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL async_reset_survivor got v=%b fu=%h exp v=0", out_valid_o, fu_o); end
  endtask

  task automatic test_random();
    logic [PW-1:0] q[$];
    logic [PW-1:0] exp_pl, got_pl;
    logic in_f, out_f;
    int errs = 0;
    apply_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, 8'($urandom));
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 99) < 3);
      in_f  = in_valid_i && (q.size() < 2);
      out_f = (q.size() > 0) && out_ready_i;
      exp_pl = {fu_i, mem_result_i, pcplus_i, ctrl_i};
      tick();
      if (flush_i) q.delete();
      else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(exp_pl);
      end
      flush_i = 1'b0;
      got_pl = {fu_o, mem_result_o, pcplus_o, ctrl_o};
      total++;
      if (out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2) ||
          (q.size() > 0 && got_pl !== q[0]) || (q.size() == 0 && ctrl_o !== 8'h00)) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d got v=%b rdy=%b pl=%h exp v=%b rdy=%b pl=%h",
                   cyc, out_valid_o, in_ready_o, got_pl, (q.size() > 0), (q.size() < 2),
                   (q.size() > 0) ? q[0] : '0);
      end
    end
    drive(1'b0, '0, '0);
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    apply_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h77, 8'h07); tick();
    drive(1'b0, '0, '0);
    total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL perf_start got=%0d exp=0", stall_cnt_o); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (stall_cnt_o !== 16'd5) begin bad++; $display("FAIL perf_count got=%0d exp=5", stall_cnt_o); end
    total++; if (stall_cnt2 !== 2'd3) begin bad++; $display("FAIL perf_saturate got=%0d exp=3", stall_cnt2); end
    flush_i = 1'b1; tick();
    flush_i = 1'b0;
    tick();
    total++; if (stall_cnt_o !== 16'd6) begin bad++; $display("FAIL perf_flush_keep got=%0d exp=6", stall_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
